// File: rtl/latch_pipe_stage_if.sv
// Handshake bundle for latch_pipe_stage: upstream valid/ready/data,
// downstream valid/ready/data, pipeline control and the occupancy count.
// The "master" side drives the stage; the "slave" side is the stage itself.
interface latch_pipe_stage_if #(
  parameter int DATA_W = 64
);
  logic              i_valid;
  logic [DATA_W-1:0] i_data;
  logic              o_ready;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              i_ready;
  logic              is_stall;
  logic              is_flush;
  logic [1:0]        o_count;

  modport master (
    output i_valid, i_data, i_ready, is_stall, is_flush,
    input  o_ready, o_valid, o_data, o_count
  );

  modport slave (
    input  i_valid, i_data, i_ready, is_stall, is_flush,
    output o_ready, o_valid, o_data, o_count
  );
endinterface

// File: rtl/latch_pipe_stage.sv
// latch_pipe_stage: one pipeline register stage between two valid/ready
// handshakes with stall (freeze) and flush (discard) controls.
//  SKID=1: head + skid register. o_ready depends only on state and stall,
//          so there is no combinational path from the downstream i_ready.
//  SKID=0: single head register, o_ready passes downstream readiness through.
// o_valid / o_data / o_count come straight from registers.
module latch_pipe_stage #(
  parameter int              DATA_W    = 64,
  parameter int              SKID      = 1,
  parameter logic [DATA_W-1:0] FLUSH_VAL = {DATA_W{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  latch_pipe_stage_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam bit SKID_EN = (SKID != 0);

  state_t            state_r;
  logic [DATA_W-1:0] head_r;
  logic [DATA_W-1:0] skid_r;
  logic              valid_r;
  logic [1:0]        count_r;

  logic              ready_s;
  logic              accept_s;
  logic              emit_s;

  // Upstream readiness: registered-only for the skid variant, pass-through
  // of downstream readiness for the single-entry variant. Flush does not
  // gate it; data offered in a flush cycle is simply dropped.
  generate
    if (SKID_EN) begin : g_ready_skid
      assign ready_s = (state_r != ST_TWO) & ~bus.is_stall;
    end else begin : g_ready_single
      assign ready_s = ~bus.is_stall & (~valid_r | bus.i_ready);
    end
  endgenerate

  // Handshake qualifiers; stall blocks both directions.
  always_comb begin
    accept_s = bus.i_valid & ready_s;
    emit_s   = valid_r & bus.i_ready & ~bus.is_stall;
  end

  // Occupancy state machine with head/skid data movement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_EMPTY;
      head_r  <= FLUSH_VAL;
      skid_r  <= FLUSH_VAL;
      valid_r <= 1'b0;
      count_r <= 2'd0;
    end else if (bus.is_flush) begin
      state_r <= ST_EMPTY;
      head_r  <= FLUSH_VAL;
      skid_r  <= FLUSH_VAL;
      valid_r <= 1'b0;
      count_r <= 2'd0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            head_r  <= bus.i_data;
            valid_r <= 1'b1;
            count_r <= 2'd1;
            state_r <= ST_ONE;
          end else begin
            state_r <= ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && emit_s) begin
            // Head leaves and is replaced in the same edge.
            head_r  <= bus.i_data;
            state_r <= ST_ONE;
          end else if (accept_s && SKID_EN) begin
            // Downstream did not take the head; park the new entry.
            skid_r  <= bus.i_data;
            count_r <= 2'd2;
            state_r <= ST_TWO;
          end else if (emit_s) begin
            // o_data keeps the last value; only o_valid drops.
            valid_r <= 1'b0;
            count_r <= 2'd0;
            state_r <= ST_EMPTY;
          end else begin
            state_r <= ST_ONE;
          end
        end
        ST_TWO: begin
          if (emit_s) begin
            head_r  <= skid_r;
            skid_r  <= FLUSH_VAL;
            count_r <= 2'd1;
            state_r <= ST_ONE;
          end else begin
            state_r <= ST_TWO;
          end
        end
        default: begin
          state_r <= ST_EMPTY;
          head_r  <= FLUSH_VAL;
          skid_r  <= FLUSH_VAL;
          valid_r <= 1'b0;
          count_r <= 2'd0;
        end
      endcase
    end
  end

  assign bus.o_ready = ready_s;
  assign bus.o_valid = valid_r;
  assign bus.o_data  = head_r;
  assign bus.o_count = count_r;

endmodule

// File: doc/latch_pipe_stage.md
LATCH_PIPE_STAGE -- requirements
Module: latch_pipe_stage

Interface
REQ-001 Parameter DATA_W, default 64, meaning payload width in bits (e.g. {pc, instruction}).
REQ-002 Parameter SKID, default 1, meaning 1 = two-entry skid stage with o_ready driven from registers only, 0 = single-entry stage.
REQ-003 Parameter FLUSH_VAL, default 0, meaning the value loaded into o_data on flush and on reset, DATA_W bits wide.
REQ-004 Port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit, meaning reset; it is asynchronous and active-low.
REQ-006 Port i_valid, input, 1 bit, meaning upstream offers i_data.
REQ-007 Port i_data, input, DATA_W bits, meaning upstream payload.
REQ-008 Port o_ready, output, 1 bit, meaning the stage accepts i_data this cycle.
REQ-009 Port o_valid, output, 1 bit, meaning o_data holds a live entry.
REQ-010 Port o_data, output, DATA_W bits, meaning the head-entry payload.
REQ-011 Port i_ready, input, 1 bit, meaning downstream accepts o_data.
REQ-012 Port is_stall, input, 1 bit, meaning freeze the stage (load-use hazard).
REQ-013 Port is_flush, input, 1 bit, meaning discard all entries (jump taken).
REQ-014 Port o_count, output, 2 bits, meaning number of live entries (0..2; never exceeds 1 when SKID=0).

Function
REQ-015 The stage SHALL define accept = i_valid & o_ready and emit = o_valid & i_ready & ~is_stall.
REQ-016 When SKID=1, the stage SHALL use states EMPTY (count 0), ONE (count 1, head register only) and TWO (count 2, head plus skid register).
REQ-017 When SKID=1, o_ready SHALL equal (state != TWO) & ~is_stall, with no combinational path from i_ready.
REQ-018 When SKID=0, o_ready SHALL equal ~is_stall & (~o_valid | i_ready).
REQ-019 When SKID=1, transitions SHALL be:
- EMPTY + accept -> ONE.
- ONE + accept & ~emit -> TWO, with the new data into skid.
- ONE + accept & emit -> ONE, with the new data into head.
- ONE + emit & ~accept -> EMPTY.
- TWO + emit -> ONE, with skid moving to head.
- All other combinations hold.
REQ-020 The stage SHALL deliver data strictly in acceptance order, with no loss and no duplication.
REQ-021 Latency from accept to o_valid SHALL be exactly one cycle when the stage is empty.
REQ-022 o_valid and o_data SHALL be driven directly from the head register (registered outputs).
REQ-023 is_stall=1 SHALL block accept and emit and hold all state, o_data and o_valid unchanged.
REQ-024 is_flush=1 SHALL, on the next edge, set the state to EMPTY, o_valid=0, o_data=FLUSH_VAL and clear the skid register.
REQ-025 is_flush SHALL take priority over is_stall, accept and emit; data offered in the flush cycle is dropped.
REQ-026 o_ready SHALL NOT be forced low by is_flush (the upstream handshake completes; the data is discarded).
REQ-027 While o_valid=1 and no emit occurs, o_data SHALL be held stable.
REQ-028 o_count SHALL track occupancy exactly, updated on the same edge as the state.

Reset
REQ-029 rst=0 SHALL immediately, without a clock edge, force:
- state EMPTY, o_valid=0, o_data=FLUSH_VAL, o_count=0;
- skid register = FLUSH_VAL.
REQ-030 Reset asserted mid-transfer SHALL discard all entries; the first accept after rst rises SHALL behave as from EMPTY.
REQ-031 When SKID=1, o_ready SHALL be 1 during reset unless is_stall=1; when SKID=0, it follows REQ-018.

Verification
REQ-032 The bench SHALL cover, for SKID=1 and DATA_W=64:
- Basic transfer: i_valid=1, i_data=0x00000004_8C010000 with i_ready=1 -> next cycle o_valid=1, o_data=0x00000004_8C010000, o_count=1.
- Back-pressure: i_ready=0 while accepting A=0x11 then B=0x22 -> o_count=2, o_ready=0, o_data=0x11; then i_ready=1 -> outputs 0x11, then 0x22, in order.
- Stall: with o_data=0x33 valid, is_stall=1 for 3 cycles with i_valid=1, i_ready=1 -> o_data stays 0x33, o_ready=0, no accept; normal flow resumes after.
- Flush priority: state TWO, then is_flush=1 with is_stall=1 and i_valid=1 (data 0x44) -> next cycle o_valid=0, o_data=0, o_count=0, and 0x44 never appears.
- Async reset: rst driven 0 mid-cycle while in state ONE -> o_valid=0 before the next edge; after release, accept 0x55 -> o_data=0x55 one cycle later.
- SKID=0 mode: continuous i_valid=i_ready=1 for 8 cycles with data 1..8 -> outputs 1..8 one per cycle with o_count<=1.
